mc_control_unit: RTL and testbench

//   Multi-cycle MIPS control FSM and the initiator of the PC write interface.
//   Per state it drives pc_write / pc_write_cond / pc_write_cond_ne and
//   pc_source, which the OR gate and PC register consume, plus every other

---
 rtl/mc_control_unit.sv | 173 +++++++++++++++++
 tb/tb_mc_control_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute and drives the
// PC write controls plus every datapath select and enable, decoded from state.
module mc_control_unit #(
   parameter bit EXC_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       pc_write_cond_ne,
   output logic [1:0] pc_source,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       illegal_op
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   typedef enum logic [3:0] {
      S_RST      = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMRD    = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWR    = 4'd6,
      S_RTYPE_EX = 4'd7,
      S_RTYPE_WB = 4'd8,
      S_ADDI_EX  = 4'd9,
      S_ADDI_WB  = 4'd10,
      S_BEQ      = 4'd11,
      S_BNE      = 4'd12,
      S_JUMP     = 4'd13,
      S_EXC      = 4'd14
   } state_t;

   state_t state_reg;
   logic   illegal_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= S_RST;
         illegal_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_RST:      state_reg <= S_FETCH;
            S_FETCH:    if (mem_ready) state_reg <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_RTYPE:     state_reg <= S_RTYPE_EX;
                  OP_LW, OP_SW: state_reg <= S_MEMADR;
                  OP_BEQ:       state_reg <= S_BEQ;
                  OP_BNE:       state_reg <= S_BNE;
                  OP_J:         state_reg <= S_JUMP;
                  OP_ADDI:      state_reg <= S_ADDI_EX;
                  default: begin
                     // illegal_op becomes visible in the EXC cycle itself
                     if (EXC_ON_ILLEGAL) begin
                        state_reg   <= S_EXC;
                        illegal_reg <= 1'b1;
                     end else begin
                        state_reg <= S_FETCH;
                     end
                  end
               endcase
            end
            S_MEMADR:   state_reg <= (opcode == OP_LW) ? S_MEMRD :
                                     (opcode == OP_SW) ? S_MEMWR : S_FETCH;
            S_MEMRD:    if (mem_ready) state_reg <= S_MEMWB;
            S_MEMWR:    if (mem_ready) state_reg <= S_FETCH;
            S_RTYPE_EX: state_reg <= S_RTYPE_WB;
            S_ADDI_EX:  state_reg <= S_ADDI_WB;
            // write-back, branch, jump, EXC and the unused code all retire to FETCH
            default:    state_reg <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_write         = 1'b0;
      pc_write_cond    = 1'b0;
      pc_write_cond_ne = 1'b0;
      pc_source        = 2'b00;
      iord             = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      ir_write         = 1'b0;
      reg_dst          = 1'b0;
      mem_to_reg       = 1'b0;
      reg_write        = 1'b0;
      alu_src_a        = 1'b0;
      alu_src_b        = 2'b00;
      alu_op           = 2'b00;
      case (state_reg)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE:   alu_src_b = 2'b11;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_RTYPE_EX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_RTYPE_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDI_WB:  reg_write = 1'b1;
         S_BEQ: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_source     = 2'b01;
            pc_write_cond = 1'b1;
         end
         S_BNE: begin
            alu_src_a        = 1'b1;
            alu_op           = 2'b01;
            pc_source        = 2'b01;
            pc_write_cond_ne = 1'b1;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_EXC: begin
            pc_write  = 1'b1;
            pc_source = 2'b11;
         end
         default: ;
      endcase
   end

   assign illegal_op = illegal_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: an instruction-plan queue model predicts outputs
// every cycle; directed literal checks pin the model, then random opcode/mem_ready.
module tb_mc_control_unit;

   localparam bit EXC_ON = 1'b1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, pc_write_cond_ne;
   logic [1:0] pc_source;
   logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b, alu_op;
   logic       illegal_op;

   mc_control_unit #(.EXC_ON_ILLEGAL(EXC_ON)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_write_cond_ne(pc_write_cond_ne), .pc_source(pc_source), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcw, pcwc, pcwne;
      logic [1:0] pcsrc;
      logic       iord, mrd, mwr, irw, rdst, m2r, rw, asa;
      logic [1:0] asb, aop;
      logic       ill;
   } outs_t;

   // Phases of an instruction as the model sees them
   localparam int P_RST = 0, P_FETCH = 1, P_DEC = 2, P_ADR = 3, P_RD = 4, P_MWB = 5,
                  P_WR = 6, P_REX = 7, P_RWB = 8, P_AEX = 9, P_AWB = 10, P_BEQ = 11,
                  P_BNE = 12, P_J = 13, P_EXC = 14;

   int         q[$];
   logic       m_ill = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         meas = 1'b0;
   int         meas_cnt = 0;
   logic [5:0] meas_op = 6'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic outs_t expect_of(input int ph, input logic mr, input logic ill);
      outs_t e;
      e = '0;
      case (ph)
         P_FETCH: begin e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
         P_DEC:   e.asb = 2'b11;
         P_ADR:   begin e.asa = 1; e.asb = 2'b10; end
         P_RD:    begin e.mrd = 1; e.iord = 1; end
         P_MWB:   begin e.rw = 1; e.m2r = 1; end
         P_WR:    begin e.mwr = 1; e.iord = 1; end
         P_REX:   begin e.asa = 1; e.aop = 2'b10; end
         P_RWB:   begin e.rw = 1; e.rdst = 1; end
         P_AEX:   begin e.asa = 1; e.asb = 2'b10; end
         P_AWB:   e.rw = 1;
         P_BEQ:   begin e.asa = 1; e.aop = 2'b01; e.pcsrc = 2'b01; e.pcwc = 1; end
         P_BNE:   begin e.asa = 1; e.aop = 2'b01; e.pcsrc = 2'b01; e.pcwne = 1; end
         P_J:     begin e.pcw = 1; e.pcsrc = 2'b10; end
         P_EXC:   begin e.pcw = 1; e.pcsrc = 2'b11; end
         default: ;
      endcase
      e.ill = (ph == P_RST) ? 1'b0 : ill;
      return e;
   endfunction

   // Cycles from FETCH completion through the last state, stalls excluded
   function automatic int latency_of(input logic [5:0] op);
      case (op)
         6'h00, 6'h2B, 6'h08: return 4;
         6'h23:               return 5;
         6'h04, 6'h05, 6'h02: return 3;
         default:             return EXC_ON ? 3 : 2;
      endcase
   endfunction

   task automatic plan(input logic [5:0] op);
      case (op)
         6'h00: begin q.push_back(P_REX); q.push_back(P_RWB); end
         6'h23: begin q.push_back(P_ADR); q.push_back(P_RD); q.push_back(P_MWB); end
         6'h2B: begin q.push_back(P_ADR); q.push_back(P_WR); end
         6'h04: q.push_back(P_BEQ);
         6'h05: q.push_back(P_BNE);
         6'h02: q.push_back(P_J);
         6'h08: begin q.push_back(P_AEX); q.push_back(P_AWB); end
         default: if (EXC_ON) q.push_back(P_EXC);
      endcase
   endtask

   task automatic advance(input logic rn, input logic mr, input logic [5:0] op);
      int cur;
      if (!rn) begin
         q.delete(); q.push_back(P_RST); m_ill = 1'b0;
      end else begin
         cur = q[0];
         if ((cur == P_FETCH || cur == P_RD || cur == P_WR) && !mr) begin
         end else if (cur == P_RST) begin
            q[0] = P_FETCH;
         end else if (cur == P_FETCH) begin
            q[0] = P_DEC;
         end else begin
            void'(q.pop_front());
            if (cur == P_DEC) plan(op);
            if (q.size() == 0) q.push_back(P_FETCH);
            if (q[0] == P_EXC) m_ill = 1'b1;
         end
      end
   endtask

   task automatic track_latency(input outs_t o, input logic mr, input logic [5:0] op);
      if (o.mrd && !o.iord) begin
         if (meas) begin
            chk("latency", meas_cnt, latency_of(meas_op));
            $display("instr op=%02h cycles=%0d", meas_op, meas_cnt);
            meas = 1'b0;
         end
         if (o.irw) begin meas = 1'b1; meas_cnt = 1; meas_op = op; end
      end else if (meas) begin
         if (!((o.mrd || o.mwr) && o.iord && !mr)) meas_cnt++;
         if (meas_cnt > 500) begin
            chk("fetch_return", meas_cnt, 500);
            meas = 1'b0;
         end
      end
   endtask

   task automatic step(input logic rn, input logic mr, input logic [5:0] op, output outs_t o);
      outs_t e;
      @(negedge clk);
      reset_n = rn; mem_ready = mr; opcode = op;
      if (!rn) begin q.delete(); q.push_back(P_RST); m_ill = 1'b0; meas = 1'b0; end
      #1;
      o = {pc_write, pc_write_cond, pc_write_cond_ne, pc_source, iord, mem_read,
           mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, alu_op, illegal_op};
      e = expect_of(q[0], mr, m_ill);
      chk("outputs", o, e);
      chk("pc_write_excl", (int'(o.pcw) + int'(o.pcwc) + int'(o.pcwne)) <= 1, 1);
      chk("mem_rw_excl", o.mrd & o.mwr, 0);
      track_latency(o, mr, op);
      @(posedge clk);
      advance(rn, mr, op);
   endtask

   initial begin
      outs_t      o;
      outs_t      seq[6];
      logic [7:0] b0, b1;
      logic [5:0] cur_op;
      logic       rn, mr;
      int         r;

      q.push_back(P_RST);

      // Reset held, then released: RST visible once before FETCH
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'h00, o);
      chk("reset_outputs_zero", o, 0);
      step(1'b1, 1'b1, 6'h23, o);

      // lw with mem_ready tied high
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 6'h23, seq[i]);
      b0 = {3'b0, seq[0].rw, seq[1].rw, seq[2].rw, seq[3].rw, seq[4].rw};
      b1 = {3'b0, seq[0].m2r, seq[1].m2r, seq[2].m2r, seq[3].m2r, seq[4].m2r};
      chk("lw_reg_write_seq", b0, 8'b0000_0001);
      chk("lw_mem_to_reg_seq", b1, 8'b0000_0001);
      chk("lw_memrd_iord", seq[3].iord, 1);

      // sw stalled in MEMWR, then reset mid-write
      for (int i = 0; i < 4; i++) step(1'b1, (i == 3) ? 1'b0 : 1'b1, 6'h2B, seq[i]);
      chk("sw_memwr_active", seq[3].mwr, 1);
      step(1'b0, 1'b0, 6'h2B, o);
      chk("reset_drops_mem_write", o.mwr, 0);
      chk("reset_illegal_clear", o.ill, 0);
      step(1'b1, 1'b1, 6'h02, o);
      chk("after_release_rst", o, 0);

      // Fetch stall of 3 cycles on a jump
      for (int i = 0; i < 4; i++) step(1'b1, (i == 3), 6'h02, seq[i]);
      chk("stall_first_fetch_read", seq[0].mrd, 1);
      b0 = {4'b0, seq[0].pcw, seq[1].pcw, seq[2].pcw, seq[3].pcw};
      b1 = {4'b0, seq[0].irw, seq[1].irw, seq[2].irw, seq[3].irw};
      chk("stall_pc_write_seq", b0, 8'b0000_0001);
      chk("stall_ir_write_seq", b1, 8'b0000_0001);
      step(1'b1, 1'b1, 6'h02, o);
      step(1'b1, 1'b1, 6'h02, o);
      chk("j_pc_write", o.pcw, 1);
      chk("j_pc_source", o.pcsrc, 2'b10);

      // beq then bne
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6'h04, seq[i]);
      chk("beq_cond_seq", {seq[0].pcwc, seq[1].pcwc, seq[2].pcwc}, 3'b001);
      chk("beq_pc_source", seq[2].pcsrc, 2'b01);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6'h05, seq[i]);
      chk("bne_cond_ne_seq", {seq[0].pcwne, seq[1].pcwne, seq[2].pcwne}, 3'b001);
      chk("bne_no_cond_eq", seq[2].pcwc, 0);

      // Illegal opcode and stickiness across a following R-type
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6'h3F, seq[i]);
      chk("exc_pc_source", seq[2].pcsrc, 2'b11);
      chk("exc_illegal_set", seq[2].ill, 1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 6'h00, seq[i]);
      chk("rtype_wb_reg_dst", seq[3].rdst, 1);
      chk("illegal_sticky", seq[3].ill, 1);

      // Randomized opcode, mem_ready and occasional reset
      cur_op = 6'h00;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         rn = ($urandom_range(0, 399) != 0);
         mr = ($urandom_range(0, 3) != 0);
         if (q[0] == P_FETCH || q[0] == P_RST) begin
            r = $urandom_range(0, 9);
            case (r)
               0: cur_op = 6'h00;
               1: cur_op = 6'h23;
               2: cur_op = 6'h2B;
               3: cur_op = 6'h04;
               4: cur_op = 6'h05;
               5: cur_op = 6'h02;
               6: cur_op = 6'h08;
               default: cur_op = 6'($urandom_range(0, 63));
            endcase
         end
         step(rn, mr, cur_op, o);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
